beat_sequencer: RTL



---
 rtl/beat_pkg.sv | 36 +++
 rtl/beat_digit_counter.sv | 38 +++
 rtl/beat_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// Shared beat codes, sequencer state type and beat-length derivation for the
// four-beat instruction cycle.
package beat_pkg;

  localparam logic [1:0] BEAT_S1 = 2'd0;
  localparam logic [1:0] BEAT_A1 = 2'd1;
  localparam logic [1:0] BEAT_S2 = 2'd2;
  localparam logic [1:0] BEAT_A2 = 2'd3;

  typedef enum logic [2:0] {
    StHalt,
    StS1,
    StA1,
    StS2,
    StA2
  } beat_state_e;

  function automatic int unsigned beat_len(input int unsigned word_bits,
                                           input int unsigned blackout);
    return word_bits + blackout;
  endfunction

  // HALT reports beat code 0, same as S1.
  function automatic logic [1:0] beat_code(input beat_state_e s);
    logic [1:0] code;
    code = BEAT_S1;
    unique case (s)
      StA1:    code = BEAT_A1;
      StS2:    code = BEAT_S2;
      StA2:    code = BEAT_A2;
      default: code = BEAT_S1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/beat_digit_counter.sv
// Digit counter for one beat: wraps at BEAT_LEN-1, held at zero while halted,
// frozen while stalled.
module beat_digit_counter #(
  parameter int unsigned DIG_W    = 6,
  parameter int unsigned BEAT_LEN = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             stall,
  output logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] digit_next,
  output logic             tc
);

  logic [DIG_W-1:0] digit_q;

  assign tc    = (digit_q == DIG_W'(BEAT_LEN - 1));
  assign digit = digit_q;

  always_comb begin
    digit_next = digit_q;
    if (halt) begin
      digit_next = '0;
    end else if (!stall) begin
      digit_next = tc ? '0 : digit_q + DIG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_next;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Four-beat cycle timing controller (S1, A1, S2, A2) with run/stop/single-shot control.
// Define BEAT_SEQ_STALL_EN to add the w_STALL input that freezes the sequence.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned BLACKOUT  = 4,
  parameter int unsigned DIG_W     = 6
) (
  input  logic             w_CLK,
  input  logic             w_RSTn,
`ifdef BEAT_SEQ_STALL_EN
  input  logic             w_STALL,
`endif
  input  logic             w_RUN,
  input  logic             w_SINGLE,
  input  logic             w_STOP,
  output logic [DIG_W-1:0] b_DIGIT,
  output logic [1:0]       b_BEAT,
  output logic             w_BLACKOUT,
  output logic             w_HA,
  output logic             w_STAT_READY,
  output logic             w_CI_INC,
  output logic             w_EXEC,
  output logic             w_RUNNING
);

  localparam int unsigned BeatLen = beat_len(WORD_BITS, BLACKOUT);

  beat_state_e      state_q, state_d;
  logic             run_q;
  logic             stop_q, stop_d;
  logic             single_q, single_d;
  logic             ready_q, ready_d;
  logic             ci_q, ci_d;
  logic             exec_q, exec_d;
  logic             ha_q, ha_d;
  logic             running_q, running_d;
  logic [1:0]       beat_q, beat_d;
  logic [DIG_W-1:0] digit_next;
  logic             tc;
  logic             stall;
  logic             run_rise;
  logic             run_go;

`ifdef BEAT_SEQ_STALL_EN
  assign stall = w_STALL && (state_q != StHalt);
`else
  assign stall = 1'b0;
`endif

  assign run_rise = w_RUN && !run_q;
  assign run_go   = run_rise || (w_RUN && !stop_q);

  beat_digit_counter #(
    .DIG_W   (DIG_W),
    .BEAT_LEN(BeatLen)
  ) u_digit_counter (
    .clk       (w_CLK),
    .rst_n     (w_RSTn),
    .halt      (state_q == StHalt),
    .stall     (stall),
    .digit     (b_DIGIT),
    .digit_next(digit_next),
    .tc        (tc)
  );

  always_comb begin
    state_d  = state_q;
    stop_d   = stop_q;
    single_d = single_q;
    if (run_rise) stop_d = 1'b0;
    unique case (state_q)
      StHalt: begin
        single_d = 1'b0;
        if (run_go) begin
          state_d = StS1;
        end else if (w_SINGLE) begin
          state_d  = StS1;
          single_d = 1'b1;
        end
      end
      StS1: if (tc) state_d = StA1;
      StA1: if (tc) state_d = StS2;
      StS2: if (tc) state_d = StA2;
      StA2: begin
        if (w_STOP) stop_d = 1'b1;
        if (tc) begin
          if (stop_q || w_STOP || !w_RUN || single_q) begin
            state_d  = StHalt;
            single_d = 1'b0;
          end else begin
            state_d = StS1;
          end
        end
      end
      default: state_d = StHalt;
    endcase
    if (stall) begin
      state_d  = state_q;
      stop_d   = stop_q;
      single_d = single_q;
    end
  end

  // Strobes are decoded from the next state/digit so their registers line up with b_DIGIT.
  always_comb begin
    ready_d   = ((state_d == StA1) && (digit_next < DIG_W'(WORD_BITS))) ||
                ((state_d == StS2) && (digit_next == '0));
    ci_d      = (state_d == StS1) && (digit_next == DIG_W'(BeatLen - 1));
    exec_d    = (state_d == StA2) && (digit_next < DIG_W'(WORD_BITS));
    ha_d      = (state_d == StS2) || (state_d == StA2);
    running_d = (state_d != StHalt);
    beat_d    = beat_code(state_d);
  end

  always_ff @(posedge w_CLK) begin
    if (!w_RSTn) begin
      state_q   <= StHalt;
      run_q     <= 1'b0;
      stop_q    <= 1'b0;
      single_q  <= 1'b0;
      ready_q   <= 1'b0;
      ci_q      <= 1'b0;
      exec_q    <= 1'b0;
      ha_q      <= 1'b0;
      running_q <= 1'b0;
      beat_q    <= BEAT_S1;
    end else begin
      state_q   <= state_d;
      run_q     <= w_RUN;
      stop_q    <= stop_d;
      single_q  <= single_d;
      ready_q   <= ready_d;
      ci_q      <= ci_d;
      exec_q    <= exec_d;
      ha_q      <= ha_d;
      running_q <= running_d;
      beat_q    <= beat_d;
    end
  end

  assign b_BEAT       = beat_q;
  assign w_HA         = ha_q;
  assign w_RUNNING    = running_q;
  assign w_STAT_READY = ready_q && !stall;
  assign w_CI_INC     = ci_q && !stall;
  assign w_EXEC       = exec_q && !stall;
  assign w_BLACKOUT   = (b_DIGIT >= DIG_W'(WORD_BITS)) && running_q;

endmodule
